timer0_io_regs: RTL and testbench

Memory-mapped I/O register file for Timer/Counter 0. It sits directly upstream of `timer_unit` and drives its `mem_*` register inputs. It takes the timer's next counter value back and arbitrates it against CPU writes. It also maintains the TIFR0/TIMSK0 interrupt flags and presents a prioritised interrupt request to the core.

---
 rtl/timer0_io_regs_pkg.sv | 47 ++++
 rtl/ocr_dbuf.sv | 36 +++
 rtl/timer0_io_regs.sv | 163 ++++++++++++++++
 tb/tb_timer0_io_regs.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/timer0_io_regs_pkg.sv
// Shared constants for the Timer/Counter 0 I/O register file: addresses,
// flag bit positions, interrupt vector codes and the waveform-mode decode.
package timer0_io_regs_pkg;

    localparam int ADDR_TCCR0A = 'h19;
    localparam int ADDR_TCCR0B = 'h18;
    localparam int ADDR_TCNT0  = 'h17;
    localparam int ADDR_OCR0A  = 'h16;
    localparam int ADDR_OCR0B  = 'h15;
    localparam int ADDR_TIMSK0 = 'h26;
    localparam int ADDR_TIFR0  = 'h25;

    // TIFR0 / TIMSK0 share these bit positions
    localparam int TOV0_BIT  = 0;
    localparam int OCF0A_BIT = 1;
    localparam int OCF0B_BIT = 2;
    localparam int FLAG_W    = 3;

    localparam logic [1:0] IRQ_NONE  = 2'd0;
    localparam logic [1:0] IRQ_COMPA = 2'd1;
    localparam logic [1:0] IRQ_COMPB = 2'd2;
    localparam logic [1:0] IRQ_OVF   = 2'd3;

    typedef enum logic [1:0] {
        MODE_NORMAL       = 2'd0,
        MODE_CTC          = 2'd1,
        MODE_FAST_PWM_MAX = 2'd2,
        MODE_FAST_PWM_OCR = 2'd3
    } timer_mode_e;

    // WGM = {TCCR0B.WGM02, TCCR0A.WGM01, TCCR0A.WGM00}; same table as timer_unit
    function automatic timer_mode_e decode_wgm(input logic [2:0] wgm);
        timer_mode_e m;
        case (wgm)
            3'b010:  m = MODE_CTC;
            3'b011:  m = MODE_FAST_PWM_MAX;
            3'b111:  m = MODE_FAST_PWM_OCR;
            default: m = MODE_NORMAL;
        endcase
        return m;
    endfunction

    function automatic logic is_pwm(input timer_mode_e m);
        return (m == MODE_FAST_PWM_MAX) || (m == MODE_FAST_PWM_OCR);
    endfunction

endpackage

// File: rtl/ocr_dbuf.sv
// Output-compare register double buffer: CPU writes always land in the
// buffer; the active value follows immediately outside PWM, at TOP inside it.
module ocr_dbuf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pwm_mode,
    input  logic                  update,
    output logic [DATA_WIDTH-1:0] buf_val,
    output logic [DATA_WIDTH-1:0] active_val
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_val <= '0;
        end else if (we) begin
            buf_val <= wdata;
        end
    end

    // Outside PWM the buffer mirrors the active value, so copying it every
    // cycle is a no-op except on the first clk after leaving PWM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_val <= '0;
        end else if (!pwm_mode) begin
            active_val <= we ? wdata : buf_val;
        end else if (update) begin
            active_val <= buf_val;
        end
    end

endmodule

// File: rtl/timer0_io_regs.sv
// Timer/Counter 0 memory-mapped register file: architectural registers for
// timer_unit, counter write/tick arbitration, interrupt flags and request.
module timer0_io_regs
    import timer0_io_regs_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] io_addr,
    input  logic                  io_we,
    input  logic [DATA_WIDTH-1:0] io_wdata,
    output logic [DATA_WIDTH-1:0] io_rdata,
    input  logic                  tick,
    input  logic [DATA_WIDTH-1:0] tcnt0_next,
    output logic [DATA_WIDTH-1:0] mem_tcnt0,
    output logic [DATA_WIDTH-1:0] mem_ocr0a,
    output logic [DATA_WIDTH-1:0] mem_ocr0b,
    output logic [DATA_WIDTH-1:0] mem_tccr0a,
    output logic [DATA_WIDTH-1:0] mem_tccr0b,
    output logic                  irq,
    output logic [1:0]            irq_vec,
    input  logic                  irq_ack
);

    localparam logic [DATA_WIDTH-1:0] FOC_MASK = DATA_WIDTH'(8'hC0);
    localparam logic [DATA_WIDTH-1:0] MAX_VAL  = '1;

    logic              we_tccr0a, we_tccr0b, we_tcnt0, we_ocr0a, we_ocr0b;
    logic              we_timsk0, we_tifr0;
    logic              cmp_block;
    logic [FLAG_W-1:0] tifr, timsk;
    logic [FLAG_W-1:0] flag_set, flag_clr, pending;
    logic [DATA_WIDTH-1:0] ocr0a_buf, ocr0b_buf, top_val;
    logic              pwm_mode, at_top;
    timer_mode_e       mode;

    assign we_tccr0a = io_we && (io_addr == ADDR_WIDTH'(ADDR_TCCR0A));
    assign we_tccr0b = io_we && (io_addr == ADDR_WIDTH'(ADDR_TCCR0B));
    assign we_tcnt0  = io_we && (io_addr == ADDR_WIDTH'(ADDR_TCNT0));
    assign we_ocr0a  = io_we && (io_addr == ADDR_WIDTH'(ADDR_OCR0A));
    assign we_ocr0b  = io_we && (io_addr == ADDR_WIDTH'(ADDR_OCR0B));
    assign we_timsk0 = io_we && (io_addr == ADDR_WIDTH'(ADDR_TIMSK0));
    assign we_tifr0  = io_we && (io_addr == ADDR_WIDTH'(ADDR_TIFR0));

    // Mode and TOP decode, kept expression-identical to timer_unit
    assign mode     = decode_wgm({mem_tccr0b[3], mem_tccr0a[1:0]});
    assign pwm_mode = is_pwm(mode);
    assign top_val  = ((mode == MODE_CTC) || (mode == MODE_FAST_PWM_OCR)) ? mem_ocr0a : MAX_VAL;
    assign at_top   = tick && (mem_tcnt0 == top_val);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_tccr0a <= '0;
            mem_tccr0b <= '0;
            timsk      <= '0;
        end else begin
            if (we_tccr0a) mem_tccr0a <= io_wdata;
            if (we_tccr0b) mem_tccr0b <= io_wdata & ~FOC_MASK;
            if (we_timsk0) timsk      <= io_wdata[FLAG_W-1:0];
        end
    end

    // A CPU write beats a simultaneous tick and arms the compare block
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_tcnt0 <= '0;
            cmp_block <= 1'b0;
        end else if (we_tcnt0) begin
            mem_tcnt0 <= io_wdata;
            cmp_block <= 1'b1;
        end else if (tick) begin
            mem_tcnt0 <= tcnt0_next;
            cmp_block <= 1'b0;
        end
    end

    ocr_dbuf #(.DATA_WIDTH(DATA_WIDTH)) u_ocr_dbuf_a (
        .clk        (clk),
        .reset      (reset),
        .we         (we_ocr0a),
        .wdata      (io_wdata),
        .pwm_mode   (pwm_mode),
        .update     (at_top),
        .buf_val    (ocr0a_buf),
        .active_val (mem_ocr0a)
    );

    ocr_dbuf #(.DATA_WIDTH(DATA_WIDTH)) u_ocr_dbuf_b (
        .clk        (clk),
        .reset      (reset),
        .we         (we_ocr0b),
        .wdata      (io_wdata),
        .pwm_mode   (pwm_mode),
        .update     (at_top),
        .buf_val    (ocr0b_buf),
        .active_val (mem_ocr0b)
    );

    // Flags look at the counter value before this tick's update
    always_comb begin
        flag_set = '0;
        if (tick) begin
            flag_set[OCF0A_BIT] = !cmp_block && (mem_tcnt0 == mem_ocr0a);
            flag_set[OCF0B_BIT] = !cmp_block && (mem_tcnt0 == mem_ocr0b);
            case (mode)
                MODE_NORMAL, MODE_FAST_PWM_MAX: flag_set[TOV0_BIT] = (mem_tcnt0 == MAX_VAL);
                MODE_FAST_PWM_OCR:              flag_set[TOV0_BIT] = (mem_tcnt0 == mem_ocr0a);
                default:                        flag_set[TOV0_BIT] = 1'b0;
            endcase
        end
    end

    always_comb begin
        flag_clr = '0;
        if (we_tifr0) flag_clr = io_wdata[FLAG_W-1:0];
        if (irq_ack) begin
            case (irq_vec)
                IRQ_COMPA: flag_clr[OCF0A_BIT] = 1'b1;
                IRQ_COMPB: flag_clr[OCF0B_BIT] = 1'b1;
                IRQ_OVF:   flag_clr[TOV0_BIT]  = 1'b1;
                default:   ;
            endcase
        end
    end

    // Set is OR-ed in after the clear so a coincident set always survives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tifr <= '0;
        end else begin
            tifr <= (tifr & ~flag_clr) | flag_set;
        end
    end

    // irq/irq_ack handshake: irq holds while any enabled flag is pending;
    // irq_ack in a cycle consumes exactly the source named by irq_vec then.
    assign pending = tifr & timsk;
    assign irq     = |pending;

    always_comb begin
        irq_vec = IRQ_NONE;
        if (pending[OCF0A_BIT])     irq_vec = IRQ_COMPA;
        else if (pending[OCF0B_BIT]) irq_vec = IRQ_COMPB;
        else if (pending[TOV0_BIT])  irq_vec = IRQ_OVF;
    end

    always_comb begin
        io_rdata = '0;
        case (io_addr)
            ADDR_WIDTH'(ADDR_TCCR0A): io_rdata = mem_tccr0a;
            ADDR_WIDTH'(ADDR_TCCR0B): io_rdata = mem_tccr0b;
            ADDR_WIDTH'(ADDR_TCNT0):  io_rdata = mem_tcnt0;
            ADDR_WIDTH'(ADDR_OCR0A):  io_rdata = ocr0a_buf;
            ADDR_WIDTH'(ADDR_OCR0B):  io_rdata = ocr0b_buf;
            ADDR_WIDTH'(ADDR_TIMSK0): io_rdata = {{(DATA_WIDTH-FLAG_W){1'b0}}, timsk};
            ADDR_WIDTH'(ADDR_TIFR0):  io_rdata = {{(DATA_WIDTH-FLAG_W){1'b0}}, tifr};
            default:                  io_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer0_io_regs.sv
// Directed bench for timer0_io_regs: counter/tick arbitration, compare block,
// flag set/clear priority, OCR double buffering, irq priority and reset.
module tb_timer0_io_regs;

    localparam logic [5:0] A_TCCR0A = 6'h19;
    localparam logic [5:0] A_TCCR0B = 6'h18;
    localparam logic [5:0] A_TCNT0  = 6'h17;
    localparam logic [5:0] A_OCR0A  = 6'h16;
    localparam logic [5:0] A_OCR0B  = 6'h15;
    localparam logic [5:0] A_TIMSK0 = 6'h26;
    localparam logic [5:0] A_TIFR0  = 6'h25;

    logic       clk;
    logic       reset;
    logic [5:0] io_addr;
    logic       io_we;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       tick;
    logic [7:0] tcnt0_next;
    logic [7:0] mem_tcnt0, mem_ocr0a, mem_ocr0b, mem_tccr0a, mem_tccr0b;
    logic       irq;
    logic [1:0] irq_vec;
    logic       irq_ack;

    int n_checks = 0;
    int n_fail   = 0;

    timer0_io_regs #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .io_addr    (io_addr),
        .io_we      (io_we),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .tick       (tick),
        .tcnt0_next (tcnt0_next),
        .mem_tcnt0  (mem_tcnt0),
        .mem_ocr0a  (mem_ocr0a),
        .mem_ocr0b  (mem_ocr0b),
        .mem_tccr0a (mem_tccr0a),
        .mem_tccr0b (mem_tccr0b),
        .irq        (irq),
        .irq_vec    (irq_vec),
        .irq_ack    (irq_ack)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] addr, input logic [7:0] data);
        io_addr  = addr;
        io_wdata = data;
        io_we    = 1'b1;
        step();
        io_we    = 1'b0;
    endtask

    task automatic do_tick(input logic [7:0] nxt);
        tcnt0_next = nxt;
        tick       = 1'b1;
        step();
        tick       = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [5:0] addr, input logic [7:0] exp);
        io_addr = addr;
        #1;
        check(tag, io_rdata, exp);
    endtask

    initial begin
        reset = 1'b1; io_addr = '0; io_we = 1'b0; io_wdata = '0;
        tick = 1'b0; tcnt0_next = '0; irq_ack = 1'b0;
        #12;
        check("reset_tcnt0", mem_tcnt0, 8'h00);
        check("reset_irq", {7'd0, irq}, 8'h00);
        check("reset_irq_vec", {6'd0, irq_vec}, 8'h00);
        rd_check("reset_rd_tifr", A_TIFR0, 8'h00);
        reset = 1'b0;
        step();

        // NORMAL mode overflow
        wr(A_TCNT0, 8'hFE);
        check("tcnt_write", mem_tcnt0, 8'hFE);
        do_tick(8'hFF);
        check("tick1_tcnt", mem_tcnt0, 8'hFF);
        rd_check("tick1_tifr", A_TIFR0, 8'h00);
        do_tick(8'h00);
        check("tick2_tcnt", mem_tcnt0, 8'h00);
        rd_check("tov_set", A_TIFR0, 8'h01);
        check("tov_masked_irq", {7'd0, irq}, 8'h00);
        wr(A_TIMSK0, 8'hFF);
        rd_check("timsk_rd", A_TIMSK0, 8'h07);
        wr(A_TIMSK0, 8'h01);
        check("tov_irq", {7'd0, irq}, 8'h01);
        check("tov_vec", {6'd0, irq_vec}, 8'h03);
        wr(A_TIFR0, 8'h01);
        rd_check("tov_w1c", A_TIFR0, 8'h00);
        check("tov_w1c_irq", {7'd0, irq}, 8'h00);

        // CPU write beats tick; compare block
        wr(A_OCR0A, 8'h10);
        check("ocr0a_normal", mem_ocr0a, 8'h10);
        wr(A_OCR0B, 8'h33);
        io_addr = A_TCNT0; io_wdata = 8'h10; io_we = 1'b1;
        tcnt0_next = 8'h42; tick = 1'b1;
        step();
        io_we = 1'b0; tick = 1'b0;
        check("write_beats_tick", mem_tcnt0, 8'h10);
        do_tick(8'h11);
        rd_check("cmp_blocked", A_TIFR0, 8'h00);
        do_tick(8'hFF);
        do_tick(8'h00);
        do_tick(8'h10);
        do_tick(8'h11);
        rd_check("ocf0a_after_wrap", A_TIFR0, 8'h03);

        // priority and irq_ack
        wr(A_TIMSK0, 8'h07);
        check("prio_vec_compa", {6'd0, irq_vec}, 8'h01);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        rd_check("ack1_tifr", A_TIFR0, 8'h01);
        check("ack1_vec", {6'd0, irq_vec}, 8'h03);
        check("ack1_irq", {7'd0, irq}, 8'h01);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        rd_check("ack2_tifr", A_TIFR0, 8'h00);
        check("ack2_irq", {7'd0, irq}, 8'h00);
        check("ack2_vec", {6'd0, irq_vec}, 8'h00);

        // set beats simultaneous clear
        do_tick(8'h10);
        io_addr = A_TIFR0; io_wdata = 8'h02; io_we = 1'b1;
        tcnt0_next = 8'h11; tick = 1'b1;
        step();
        io_we = 1'b0; tick = 1'b0;
        rd_check("set_wins", A_TIFR0, 8'h02);
        check("set_wins_vec", {6'd0, irq_vec}, 8'h01);
        wr(A_TIFR0, 8'h00);
        rd_check("w0_no_effect", A_TIFR0, 8'h02);
        wr(A_TIFR0, 8'h02);
        rd_check("ocf0a_w1c", A_TIFR0, 8'h00);

        // FAST_PWM_OCR double buffering
        wr(A_OCR0A, 8'h80);
        wr(A_TCCR0A, 8'h03);
        wr(A_TCCR0B, 8'hC8);
        rd_check("tccr0b_foc", A_TCCR0B, 8'h08);
        check("mem_tccr0b", mem_tccr0b, 8'h08);
        check("mem_tccr0a", mem_tccr0a, 8'h03);
        wr(A_TCNT0, 8'h20);
        wr(A_OCR0A, 8'h40);
        check("pwm_ocr0a_held", mem_ocr0a, 8'h80);
        rd_check("pwm_ocr0a_buf", A_OCR0A, 8'h40);
        do_tick(8'h80);
        check("pwm_before_top", mem_ocr0a, 8'h80);
        do_tick(8'h00);
        check("pwm_at_top", mem_ocr0a, 8'h40);
        rd_check("pwm_top_flags", A_TIFR0, 8'h03);
        check("pwm_top_vec", {6'd0, irq_vec}, 8'h01);

        // leaving PWM copies the buffer on the next clk
        wr(A_OCR0B, 8'h55);
        check("pwm_ocr0b_held", mem_ocr0b, 8'h33);
        rd_check("pwm_ocr0b_buf", A_OCR0B, 8'h55);
        wr(A_TCCR0A, 8'h00);
        check("leave_pwm_edge", mem_ocr0b, 8'h33);
        step();
        check("leave_pwm_copy", mem_ocr0b, 8'h55);

        // asynchronous reset mid-PWM with a loaded buffer
        wr(A_TCCR0A, 8'h03);
        wr(A_OCR0B, 8'h66);
        check("reload_held", mem_ocr0b, 8'h55);
        #2;
        reset = 1'b1;
        #1;
        check("areset_tcnt0", mem_tcnt0, 8'h00);
        check("areset_ocr0a", mem_ocr0a, 8'h00);
        check("areset_ocr0b", mem_ocr0b, 8'h00);
        check("areset_tccr0a", mem_tccr0a, 8'h00);
        check("areset_tccr0b", mem_tccr0b, 8'h00);
        check("areset_irq", {7'd0, irq}, 8'h00);
        check("areset_vec", {6'd0, irq_vec}, 8'h00);
        rd_check("areset_tifr", A_TIFR0, 8'h00);
        rd_check("areset_ocr0b_buf", A_OCR0B, 8'h00);
        reset = 1'b0;
        step();
        check("post_reset_ocr0b", mem_ocr0b, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
